// File: rtl/pll_dps_ctrl.sv
// pll_dps_ctrl: initiator side of the PLL dynamic-phase-shift interface.
// Takes phase-step requests (counter, direction, step count), issues one
// phase_en pulse per step, handshakes on phase_done and keeps a saturating
// signed net-step accumulator per PLL output counter for readback.
// Optional feature macro: DPS_TIMEOUT_EN bounds the phase_done waits to
// TIMEOUT_CYC cycles; without it the waits are unbounded.
module pll_dps_ctrl #(
    parameter int NUM_CNT     = 8,
    parameter int STEP_W      = 8,
    parameter int OFF_W       = 12,
    parameter int PULSE_CYC   = 2,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              scanclk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_cntsel,
    input  logic              req_updn,
    input  logic [STEP_W-1:0] req_steps,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    input  logic              phase_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [4:0]        rd_sel,
    output logic [OFF_W-1:0]  rd_offset
);

    // One shared cycle counter, wide enough for pulse, gap and timeout spans.
    localparam int CNT_W = $clog2(TIMEOUT_CYC + PULSE_CYC + GAP_CYC + 1);
    localparam logic signed [OFF_W-1:0] OFF_MAX = {1'b0, {(OFF_W-1){1'b1}}};
    localparam logic signed [OFF_W-1:0] OFF_MIN = {1'b1, {(OFF_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_GAP
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_pd_q;
    logic                     r_lo_seen;
    logic [CNT_W-1:0]         r_cnt;
    logic [STEP_W-1:0]        r_remain;
    logic [4:0]               r_cntsel;
    logic                     r_updn;
    logic                     r_phase_en;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic signed [OFF_W-1:0]  r_acc [NUM_CNT];

    logic                     w_accept;
    logic                     w_step_ok;
    logic                     w_done;
    logic                     w_err;
    logic [OFF_W-1:0]         w_rd_offset;

    assign req_ready = (r_state == S_IDLE) & locked;
    assign w_accept  = req_valid & req_ready;

    assign phase_en  = r_phase_en;
    assign updn      = r_updn;
    assign cntsel    = r_cntsel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign rd_offset = w_rd_offset;

    // Next-state decode, step-completion strobe and done/err pulse requests.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_step_ok    = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (int'(req_cntsel) >= NUM_CNT) begin
                        w_done = 1'b1;
                        w_err  = 1'b1;
                    end else if (req_steps == '0) begin
                        w_done = 1'b1;
                    end else begin
                        w_next_state = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (r_cnt == CNT_W'(PULSE_CYC - 1)) w_next_state = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // A low phase_done already observed while pulsing satisfies this wait.
                if (!r_pd_q || r_lo_seen) w_next_state = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (r_pd_q) begin
                    w_step_ok = 1'b1;
                    if (r_remain == STEP_W'(1)) begin
                        w_next_state = S_IDLE;
                        w_done       = 1'b1;
                    end else begin
                        w_next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) w_next_state = S_PULSE;
            end
            default: w_next_state = S_IDLE;
        endcase
`ifdef DPS_TIMEOUT_EN
        if ((r_state == S_WAIT_LO || r_state == S_WAIT_HI) &&
            r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            w_next_state = S_IDLE;
            w_step_ok    = 1'b0;
            w_done       = 1'b1;
            w_err        = 1'b1;
        end
`endif
        // Loss of lock aborts any operation; the step in flight is not counted.
        if (r_state != S_IDLE && !locked) begin
            w_next_state = S_IDLE;
            w_step_ok    = 1'b0;
            w_done       = 1'b1;
            w_err        = 1'b1;
        end
    end

    // State register, cycle counter, latched request and registered PLL-side outputs.
    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pd_q     <= 1'b1;
            r_lo_seen  <= 1'b0;
            r_cnt      <= '0;
            r_remain   <= '0;
            r_cntsel   <= '0;
            r_updn     <= 1'b0;
            r_phase_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            r_state    <= w_next_state;
            r_pd_q     <= phase_done;
            r_phase_en <= (w_next_state == S_PULSE);
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= w_done;
            r_err      <= w_err;

            if (w_next_state != r_state) r_cnt <= '0;
            else                         r_cnt <= r_cnt + CNT_W'(1);

            if (r_state != S_PULSE && w_next_state == S_PULSE) r_lo_seen <= 1'b0;
            else if (r_state == S_PULSE && !r_pd_q)            r_lo_seen <= 1'b1;

            if (w_accept) begin
                r_cntsel <= req_cntsel;
                r_updn   <= req_updn;
                r_remain <= req_steps;
            end else if (w_step_ok) begin
                r_remain <= r_remain - STEP_W'(1);
            end
        end
    end

    // Per-counter saturating net-step accumulators.
    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the accumulator array is architectural state read by firmware, so it is reset like any register.
            for (int i = 0; i < NUM_CNT; i++) r_acc[i] <= '0;
        end else if (w_step_ok) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (int'(r_cntsel) == i) begin
                    if (r_updn) begin
                        if (r_acc[i] != OFF_MAX) r_acc[i] <= r_acc[i] + OFF_W'(1);
                    end else begin
                        if (r_acc[i] != OFF_MIN) r_acc[i] <= r_acc[i] - OFF_W'(1);
                    end
                end
            end
        end
    end

    // Combinational readback; out-of-range selects read zero.
    always_comb begin
        w_rd_offset = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (int'(rd_sel) == i) w_rd_offset = r_acc[i];
        end
    end

endmodule
